// File: rtl/mm2s_rr_merge.sv
// Two-source AXI4-Stream packet merger feeding the ACCL mm2s input.
// Round-robin arbitration between host (source 0) and card (source 1),
// packet-locked so beats never interleave, followed by a 2-entry skid
// buffer that keeps input tready independent of m_tready.
//
// state | meaning
// IDLE  | no packet in progress, grant decided combinationally each cycle
// LOCK0 | source 0 packet in progress, only source 0 may transfer
// LOCK1 | source 1 packet in progress, only source 1 may transfer
module mm2s_rr_merge #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  s00_tvalid,
    output logic                  s00_tready,
    input  logic [DATA_WIDTH-1:0] s00_tdata,
    input  logic [KEEP_WIDTH-1:0] s00_tkeep,
    input  logic                  s00_tlast,
    input  logic                  s01_tvalid,
    output logic                  s01_tready,
    input  logic [DATA_WIDTH-1:0] s01_tdata,
    input  logic [KEEP_WIDTH-1:0] s01_tkeep,
    input  logic                  s01_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [KEEP_WIDTH-1:0] m_tkeep,
    output logic                  m_tlast,
    output logic                  m_tid,
    output logic [31:0]           pkt_cnt0,
    output logic [31:0]           pkt_cnt1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_last_grant;
    logic                  r_run;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_room;
    logic                  w_acc0;
    logic                  w_acc1;
    logic                  w_push;
    logic                  w_pop;

    logic [DATA_WIDTH-1:0] r_data [2];
    logic [KEEP_WIDTH-1:0] r_keep [2];
    logic [1:0]            r_last;
    logic [1:0]            r_tid;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic [31:0]           r_pkt_cnt0;
    logic [31:0]           r_pkt_cnt1;

    // Room is judged from registered occupancy only, so m_tready never
    // reaches the source-side tready path.
    assign w_room     = (r_count != 2'd2);
    assign s00_tready = w_gnt0 & w_room;
    assign s01_tready = w_gnt1 & w_room;
    assign w_acc0     = s00_tvalid & s00_tready;
    assign w_acc1     = s01_tvalid & s01_tready;
    assign w_push     = w_acc0 | w_acc1;
    assign m_tvalid   = (r_count != 2'd0);
    assign w_pop      = m_tvalid & m_tready;

    assign m_tdata    = r_data[r_rd_ptr];
    assign m_tkeep    = r_keep[r_rd_ptr];
    assign m_tlast    = r_last[r_rd_ptr];
    assign m_tid      = r_tid[r_rd_ptr];
    assign pkt_cnt0   = r_pkt_cnt0;
    assign pkt_cnt1   = r_pkt_cnt1;

    // Arbiter state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: lock on a non-final first beat, unlock on the locked source's tlast.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_acc0 && !s00_tlast) begin
                    w_state_nxt = LOCK0;
                end else if (w_acc1 && !s01_tlast) begin
                    w_state_nxt = LOCK1;
                end
            end
            LOCK0: if (w_acc0 && s00_tlast) w_state_nxt = IDLE;
            LOCK1: if (w_acc1 && s01_tlast) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Grant decode; nothing is granted until the first clock after reset release.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_run) begin
            case (r_state)
                IDLE: begin
                    if (s00_tvalid && s01_tvalid) begin
                        w_gnt0 = r_last_grant;
                        w_gnt1 = !r_last_grant;
                    end else begin
                        w_gnt0 = s00_tvalid;
                        w_gnt1 = s01_tvalid;
                    end
                end
                LOCK0:   w_gnt0 = 1'b1;
                LOCK1:   w_gnt1 = 1'b1;
                default: ;
            endcase
        end
    end

    // Round-robin pointer tracks the source of the last packet start.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_last_grant <= 1'b1;
            r_run        <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (r_state == IDLE && w_push) begin
                r_last_grant <= w_acc1;
            end
        end
    end

    // Two-entry skid buffer; the head entry drives the master port.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < 2; i++) begin
                r_data[i] <= '0;
                r_keep[i] <= '0;
            end
            r_last   <= '0;
            r_tid    <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_data[r_wr_ptr] <= w_acc1 ? s01_tdata : s00_tdata;
                r_keep[r_wr_ptr] <= w_acc1 ? s01_tkeep : s00_tkeep;
                r_last[r_wr_ptr] <= w_acc1 ? s01_tlast : s00_tlast;
                r_tid[r_wr_ptr]  <= w_acc1;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Per-source packet counters, free-running with natural wrap.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pkt_cnt0 <= 32'd0;
            r_pkt_cnt1 <= 32'd0;
        end else begin
            if (w_acc0 && s00_tlast) r_pkt_cnt0 <= r_pkt_cnt0 + 32'd1;
            if (w_acc1 && s01_tlast) r_pkt_cnt1 <= r_pkt_cnt1 + 32'd1;
        end
    end

endmodule
